// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-port round-robin arbiter and access sequencer for the single
//            data memory. Port 0 is the CPU load/store path and port 1 is a
//            secondary master. The block issues at most one access per cycle,
//            supports bounded burst locking, returns a per-port read-valid
//            after a fixed memory latency and generates the CPU stall.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int MEM_LAT   = 1,  // memory read latency, 1..4
  parameter int MAX_BURST = 4   // max consecutive locked beats, 1..15
) (
  input  logic        clk,
  input  logic        rst,        // synchronous, active-low
  input  logic        req0,
  input  logic        req1,
  input  logic        lock0,
  input  logic        lock1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata,
  output logic        stall0,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] c_IDLE      = 2'd0;
  localparam logic [1:0] c_OWN0      = 2'd1;
  localparam logic [1:0] c_OWN1      = 2'd2;
  localparam logic [3:0] c_MAX_BURST = 4'(MAX_BURST);
  // A one-beat burst limit makes locking meaningless, so ownership is never taken.
  localparam bit         c_BURST_EN  = (MAX_BURST > 1);

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic               r_last;        // port granted most recently
  logic               w_next_last;
  logic [3:0]         r_burst_cnt;   // beats issued in the current ownership
  logic [3:0]         w_next_burst;
  logic [3:0]         w_beat_cnt;
  logic [MEM_LAT-1:0] r_pipe_vld;    // outstanding reads, one slot per cycle of latency
  logic [MEM_LAT-1:0] r_pipe_port;   // owning port of each outstanding read
  logic               w_gnt0;
  logic               w_gnt1;
  logic               w_rd_issue;

  assign w_beat_cnt = r_burst_cnt + 4'd1;
  assign w_rd_issue = (w_gnt0 & ~we0) | (w_gnt1 & ~we1);

  // State, round-robin pointer, burst counter and read-tracking pipeline.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= c_IDLE;
      r_last      <= 1'b1;      // CPU wins the first tie after reset
      r_burst_cnt <= 4'd0;
      r_pipe_vld  <= '0;        // in-flight reads are dropped
      r_pipe_port <= '0;
    end else begin
      r_state        <= w_next_state;
      r_last         <= w_next_last;
      r_burst_cnt    <= w_next_burst;
      r_pipe_vld[0]  <= w_rd_issue;
      r_pipe_port[0] <= w_gnt1;
      for (int i = 1; i < MEM_LAT; i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_port[i] <= r_pipe_port[i-1];
      end
    end
  end

  // Next-state: ownership entry/exit, burst counting and round-robin update.
  always_comb begin
    w_next_state = r_state;
    w_next_last  = r_last;
    w_next_burst = r_burst_cnt;
    case (r_state)
      c_IDLE: begin
        w_next_burst = 4'd0;
        if (w_gnt0) begin
          w_next_last = 1'b0;
          if (lock0 && c_BURST_EN) begin
            w_next_state = c_OWN0;
            w_next_burst = 4'd1;
          end
        end else if (w_gnt1) begin
          w_next_last = 1'b1;
          if (lock1 && c_BURST_EN) begin
            w_next_state = c_OWN1;
            w_next_burst = 4'd1;
          end
        end
      end
      c_OWN0: begin
        if (w_gnt0) begin
          // Keeping last = owner hands the next tie to the other port.
          w_next_last  = 1'b0;
          w_next_burst = w_beat_cnt;
          if (!lock0 || (w_beat_cnt == c_MAX_BURST)) begin
            w_next_state = c_IDLE;
            w_next_burst = 4'd0;
          end
        end else begin
          w_next_state = c_IDLE;
          w_next_burst = 4'd0;
        end
      end
      c_OWN1: begin
        if (w_gnt1) begin
          w_next_last  = 1'b1;
          w_next_burst = w_beat_cnt;
          if (!lock1 || (w_beat_cnt == c_MAX_BURST)) begin
            w_next_state = c_IDLE;
            w_next_burst = 4'd0;
          end
        end else begin
          w_next_state = c_IDLE;
          w_next_burst = 4'd0;
        end
      end
      default: begin
        w_next_state = c_IDLE;
        w_next_burst = 4'd0;
      end
    endcase
  end

  // Grant decision: zero-cycle, blocked entirely while reset is asserted.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (rst) begin
      case (r_state)
        c_IDLE: begin
          if (req0 && req1) begin
            w_gnt0 = r_last;
            w_gnt1 = ~r_last;
          end else begin
            w_gnt0 = req0;
            w_gnt1 = req1;
          end
        end
        c_OWN0:  w_gnt0 = req0;
        c_OWN1:  w_gnt1 = req1;
        default: ;
      endcase
    end
  end

  // Output muxing: memory command from the granted port, stall and read-valids.
  always_comb begin
    gnt0      = w_gnt0;
    gnt1      = w_gnt1;
    stall0    = req0 & ~w_gnt0;
    rdata     = mem_rdata;
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if (w_gnt0) begin
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (w_gnt1) begin
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
    rvalid0 = rst & r_pipe_vld[MEM_LAT-1] & ~r_pipe_port[MEM_LAT-1];
    rvalid1 = rst & r_pipe_vld[MEM_LAT-1] &  r_pipe_port[MEM_LAT-1];
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter: vector table, directed
//            multi-cycle sequences and randomized traffic against a
//            transaction-level reference model with a memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int MEM_LAT   = 3;
  localparam int MAX_BURST = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, lock, we;
  logic [31:0] addr [2];
  logic [31:0] wdata[2];
  logic        gnt0, gnt1, rvalid0, rvalid1, stall0, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  dmem_arbiter #(.MEM_LAT(MEM_LAT), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .req0(req[0]), .req1(req[1]), .lock0(lock[0]), .lock1(lock[1]),
    .we0(we[0]), .we1(we[1]), .addr0(addr[0]), .addr1(addr[1]),
    .wdata0(wdata[0]), .wdata1(wdata[1]),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .stall0(stall0), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    return 32'hC0DE_0000 + 32'(i * 17);
  endfunction

  // Memory model: word array, read data appears MEM_LAT cycles after the address.
  logic [31:0] mem  [256];
  logic [31:0] dpipe[MEM_LAT];
  bit          mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
    dpipe[0] <= mem[mem_addr[9:2]];
    for (int i = 1; i < MEM_LAT; i++) dpipe[i] <= dpipe[i-1];
  end
  assign mem_rdata = dpipe[MEM_LAT-1];

  // Reference model state (transaction level).
  logic [31:0] ref_mem[256];
  int          m_owner, m_beats, m_last, m_g, cyc;
  bit          ev_v[64];
  int          ev_p[64];
  logic [31:0] ev_d[64];
  int          nerr = 0, nchk = 0;

  logic        s_gnt0, s_gnt1, s_stall0, s_we, s_rv0, s_rv1;
  logic [31:0] s_addr, s_wdata, s_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: compare outputs with the model, then advance the model.
  task automatic step();
    int g, slot, s;
    #3;
    g = -1;
    if (rst) begin
      if (m_owner >= 0) begin
        if (req[m_owner]) g = m_owner;
      end else if (req[0] && req[1]) g = 1 - m_last;
      else if (req[0]) g = 0;
      else if (req[1]) g = 1;
    end
    m_g  = g;
    slot = cyc % 64;
    s_gnt0 = gnt0; s_gnt1 = gnt1; s_stall0 = stall0; s_we = mem_we;
    s_addr = mem_addr; s_wdata = mem_wdata; s_rv0 = rvalid0; s_rv1 = rvalid1;
    s_rdata = rdata;
    chk("gnt0", gnt0, 32'(g == 0));
    chk("gnt1", gnt1, 32'(g == 1));
    chk("stall0", stall0, 32'(req[0] && g != 0));
    chk("mem_we", mem_we, (g >= 0) ? 32'(we[g]) : 32'd0);
    chk("mem_addr", mem_addr, (g >= 0) ? addr[g] : 32'd0);
    chk("mem_wdata", mem_wdata, (g >= 0) ? wdata[g] : 32'd0);
    chk("rvalid0", rvalid0, 32'(rst && ev_v[slot] && ev_p[slot] == 0));
    chk("rvalid1", rvalid1, 32'(rst && ev_v[slot] && ev_p[slot] == 1));
    if (rst && ev_v[slot]) chk("rdata", rdata, ev_d[slot]);
    @(posedge clk);
    if (!rst) begin
      m_owner = -1; m_last = 1; m_beats = 0;
      for (int i = 0; i < 64; i++) ev_v[i] = 1'b0;
    end else begin
      ev_v[slot] = 1'b0;
      if (g >= 0 && we[g]) ref_mem[addr[g][9:2]] = wdata[g];
      if (g >= 0 && !we[g]) begin
        s = (cyc + MEM_LAT) % 64;
        ev_v[s] = 1'b1; ev_p[s] = g; ev_d[s] = ref_mem[addr[g][9:2]];
      end
      if (m_owner >= 0) begin
        if (g == m_owner) begin
          m_beats++;
          if (!lock[g] || m_beats >= MAX_BURST) m_owner = -1;
        end else m_owner = -1;
      end else if (g >= 0 && lock[g] && MAX_BURST > 1) begin
        m_owner = g; m_beats = 1;
      end
      if (g >= 0) m_last = g;
    end
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b1; req = 2'b00; lock = 2'b00; we = 2'b00;
  endtask

  typedef struct {
    bit       rst;
    bit [1:0] req, lock, we;
    bit       eg0, eg1, es0;
  } vec_t;
  vec_t tbl[13];

  logic rv_hist0[8], rv_hist1[8];
  logic [31:0] rd_hist[8];

  initial begin
    rst = 1'b0; req = 2'b00; lock = 2'b00; we = 2'b00;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    for (int i = 0; i < 64; i++) ev_v[i] = 1'b0;
    m_owner = -1; m_last = 1; m_beats = 0; m_g = -1; cyc = 0;

    // rst  req    lock   we     gnt0 gnt1 stall0
    tbl[0]  = '{0, 2'b00, 2'b00, 2'b11, 0, 0, 0};
    tbl[1]  = '{1, 2'b11, 2'b00, 2'b11, 1, 0, 0};  // alternation from reset
    tbl[2]  = '{1, 2'b11, 2'b00, 2'b11, 0, 1, 1};
    tbl[3]  = '{1, 2'b11, 2'b00, 2'b11, 1, 0, 0};
    tbl[4]  = '{1, 2'b11, 2'b00, 2'b11, 0, 1, 1};
    tbl[5]  = '{1, 2'b11, 2'b10, 2'b11, 1, 0, 0};
    tbl[6]  = '{1, 2'b11, 2'b10, 2'b11, 0, 1, 1};  // port 1 locked burst
    tbl[7]  = '{1, 2'b11, 2'b10, 2'b11, 0, 1, 1};
    tbl[8]  = '{1, 2'b11, 2'b10, 2'b11, 0, 1, 1};
    tbl[9]  = '{1, 2'b11, 2'b10, 2'b11, 0, 1, 1};  // MAX_BURST reached
    tbl[10] = '{1, 2'b11, 2'b10, 2'b11, 1, 0, 0};
    tbl[11] = '{0, 2'b11, 2'b00, 2'b11, 0, 0, 1};  // grants blocked in reset
    tbl[12] = '{1, 2'b11, 2'b00, 2'b11, 1, 0, 0};

    @(posedge clk); #1;
    step();
    for (int i = 0; i < 13; i++) begin
      rst = tbl[i].rst; req = tbl[i].req; lock = tbl[i].lock; we = tbl[i].we;
      addr[0] = 32'h40; addr[1] = 32'h44; wdata[0] = $urandom; wdata[1] = $urandom;
      step();
      chk("tbl_gnt0", s_gnt0, 32'(tbl[i].eg0));
      chk("tbl_gnt1", s_gnt1, 32'(tbl[i].eg1));
      chk("tbl_stall0", s_stall0, 32'(tbl[i].es0));
    end

    // Preload 0x10 through port 1, reset, then CPU read returns it.
    idle_inputs(); req = 2'b10; we = 2'b10; addr[1] = 32'h10; wdata[1] = 32'hDEADBEEF;
    step(); chk("pre_gnt1", s_gnt1, 1);
    idle_inputs(); rst = 1'b0; step();
    idle_inputs(); req = 2'b01; addr[0] = 32'h10; step();
    chk("rd_gnt0", s_gnt0, 1);
    idle_inputs();
    for (int k = 1; k <= MEM_LAT; k++) step();
    chk("rd_rvalid0", s_rv0, 1); chk("rd_rvalid1", s_rv1, 0);
    chk("rd_data", s_rdata, 32'hDEADBEEF);

    // Back-to-back reads: port 0 at T, T+1, port 1 at T+2.
    idle_inputs(); req = 2'b01; addr[0] = 32'h100; step();
    addr[0] = 32'h104; step();
    req = 2'b10; addr[1] = 32'h108; step();
    idle_inputs();
    for (int k = 3; k < 8; k++) begin
      step(); rv_hist0[k] = s_rv0; rv_hist1[k] = s_rv1; rd_hist[k] = s_rdata;
    end
    chk("b2b_rv0_a", rv_hist0[MEM_LAT], 1);
    chk("b2b_rd_a", rd_hist[MEM_LAT], init_word(32'h40));
    chk("b2b_rv0_b", rv_hist0[MEM_LAT+1], 1);
    chk("b2b_rd_b", rd_hist[MEM_LAT+1], init_word(32'h41));
    chk("b2b_rv1_c", rv_hist1[MEM_LAT+2], 1);
    chk("b2b_rv0_c", rv_hist0[MEM_LAT+2], 0);
    chk("b2b_rd_c", rd_hist[MEM_LAT+2], init_word(32'h42));

    // Read dropped by reset on the following edge.
    idle_inputs(); req = 2'b10; we = 2'b10; addr[1] = 32'h0; step();  // leave last=1
    idle_inputs(); req = 2'b01; addr[0] = 32'h10; step();
    idle_inputs(); rst = 1'b0; step();
    idle_inputs();
    for (int k = 0; k < MEM_LAT + 2; k++) begin
      step(); chk("rst_no_rvalid0", s_rv0, 0);
    end
    req = 2'b11; we = 2'b11; step();
    chk("rst_tie_gnt0", s_gnt0, 1);

    // Write then readback.
    idle_inputs(); req = 2'b01; we = 2'b01; addr[0] = 32'h20; wdata[0] = 32'h12345678; step();
    chk("wr_mem_we", s_we, 1); chk("wr_mem_addr", s_addr, 32'h20);
    chk("wr_mem_wdata", s_wdata, 32'h12345678);
    idle_inputs(); req = 2'b01; addr[0] = 32'h20; step();
    idle_inputs();
    for (int k = 1; k <= MEM_LAT; k++) step();
    chk("wr_rb_rvalid0", s_rv0, 1); chk("wr_rb_data", s_rdata, 32'h12345678);

    // Randomized traffic honouring the hold-until-granted rule.
    for (int n = 0; n < 3000; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!(req[p] && m_g != p)) begin
          req[p]   = ($urandom_range(0, 2) != 0);
          we[p]    = $urandom_range(0, 1) != 0;
          addr[p]  = 32'($urandom_range(0, 255)) << 2;
          wdata[p] = $urandom;
        end
      end
      lock = 2'($urandom_range(0, 3));
      rst  = ($urandom_range(0, 63) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the single data memory behind the pipeline's memory/write-back stage. Port 0 is the CPU's stage-3 load/store path; port 1 is a secondary master (program/data loader or debug DMA). It issues at most one access per cycle and shares the memory round-robin, with bounded burst locking. It returns read data with a per-port valid after a fixed memory latency and produces the CPU stall for lost arbitration.

## Interface
- MEM_LAT, 1, memory read latency in cycles (legal 1..4)
- MAX_BURST, 4, maximum consecutive locked beats per grant (legal 1..15)
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, synchronous, active-low
- req0 / req1  input  1  access request, port 0 / port 1
- lock0 / lock1  input  1  request to keep ownership for following beats
- we0 / we1  input  1  1 = write, 0 = read
- addr0 / addr1  input  32  byte address
- wdata0 / wdata1  input  32  write data
- gnt0 / gnt1  output  1  access issued this cycle (combinational)
- rvalid0 / rvalid1  output  1  read data valid for that port
- rdata  output  32  shared read-data bus (= mem_rdata)
- stall0  output  1  req0 & ~gnt0, CPU pipeline hold
- mem_we  output  1  memory write enable
- mem_addr  output  32  memory address
- mem_wdata  output  32  memory write data
- mem_rdata  input  32  memory read data, valid MEM_LAT cycles after address

## Operation
- States: IDLE, OWN0, OWN1. Registers: state, last (last-granted port), burst_cnt (4 bits), rd_pipe[MEM_LAT] of {valid, port}.
- IDLE: exactly one req -> that port granted. Both req -> port != last granted. Grant with lock=1 and MAX_BURST>1 -> OWNn, burst_cnt=1. Otherwise stay IDLE. last updates to each granted port.
- OWNn: port n granted whenever reqn=1; burst_cnt increments per granted beat. Exit to IDLE when reqn=0, lockn=0, or the beat taking burst_cnt to MAX_BURST is issued. The other port's req is ignored while in OWNn.
- After a forced exit at MAX_BURST, the other port wins the next tie (last = n).
- Memory mux: granted port's we/addr/wdata drive mem_*; no grant -> mem_we=0, mem_addr=0, mem_wdata=0. gnt0 and gnt1 are never both 1.
- Reads: a granted read pushes {1, port} into rd_pipe. rvalidn=1 exactly MEM_LAT cycles later, for that port only. rdata always follows mem_rdata.
- Writes: completion is the gnt cycle; no rvalid.
- Requester holds req/we/addr/wdata stable until it sees gnt, and may change them the following cycle.
- Reset (rst=0 at a clock edge): state=IDLE, last=1 (CPU wins first tie), burst_cnt=0, rd_pipe cleared. In-flight reads are dropped and no rvalid is emitted for them. Combinational outputs follow the muxing rules in the same cycle, with gnt forced 0 while rst=0.

## Timing
- Grant decision is combinational on req/lock and registered state: zero-cycle grant.
- Read latency: issue at cycle T -> rvalid at T+MEM_LAT. Back-to-back reads give one rvalid per cycle.
- stall0 is asserted in every cycle req0=1 and gnt0=0. With alternating contention, maximum CPU wait is MAX_BURST cycles.
- Simultaneous req in IDLE with last=0 -> port 1 granted, stall0=1 for that cycle.
- Lock asserted on a read followed by writes: the mix is allowed, and rd_pipe tracks only reads.
- MAX_BURST=1: lock has no effect and the block never leaves IDLE.

## Test plan
- Reset then CPU read addr 0x10, MEM_LAT=1, memory model returns 0xDEADBEEF -> gnt0 same cycle, rvalid0=1 with rdata=0xDEADBEEF next cycle, rvalid1=0.
- req0=req1=1 held continuously, no lock, from reset -> grants alternate 0,1,0,1, stall0 pattern 0,1,0,1.
- Port 1 lock=1, req1 held, req0 held, MAX_BURST=4 -> gnt1 for 4 consecutive cycles, then gnt0, stall0 high for exactly 4 cycles.
- MEM_LAT=3, CPU reads at T, T+1 and port-1 read at T+2 -> rvalid0 at T+3, T+4 and rvalid1 at T+5, with rdata matching each address.
- CPU read issued, rst=0 on the next edge -> no rvalid0 ever, state IDLE, next tie goes to port 0.
- CPU write 0x20 <- 0x12345678 -> mem_we=1, mem_addr=0x20, mem_wdata=0x12345678 in the gnt0 cycle. Readback returns 0x12345678.
